// File: rtl/alu_pkg.sv
// Shared definitions for the 32-bit registered ALU and its request arbiter:
// operand/opcode widths, opcode encodings, sequencer state encoding, the
// issue payload struct, and an opcode legality helper.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned SHIFT_W = 5;

  // ALU opcodes; anything above OP_MAX is rejected without touching the ALU
  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_AND  = 4'h2;
  localparam logic [OP_W-1:0] OP_OR   = 4'h3;
  localparam logic [OP_W-1:0] OP_SLL  = 4'h4;
  localparam logic [OP_W-1:0] OP_SRL  = 4'h5;
  localparam logic [OP_W-1:0] OP_SRA  = 4'h6;
  localparam logic [OP_W-1:0] OP_SLT  = 4'h7;
  localparam logic [OP_W-1:0] OP_SLTU = 4'h8;
  localparam logic [OP_W-1:0] OP_NOR  = 4'h9;
  localparam logic [OP_W-1:0] OP_XOR  = 4'hA;
  localparam logic [OP_W-1:0] OP_MAX  = OP_XOR;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  // One ALU operation as presented by a requester
  typedef struct packed {
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [OP_W-1:0]    op;
    logic [SHIFT_W-1:0] shift;
  } alu_req_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant.
// Ports:
//   valid      - request vector, bit i = requester i
//   last_port  - requester served most recently
//   grant_any  - at least one requester is valid
//   grant_port - index of the winning requester (meaningful with grant_any)
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_port,
  output logic       grant_any,
  output logic       grant_port
);

  // A lone requester always wins; on a tie the one not served last wins
  always_comb begin
    grant_any  = |valid;
    grant_port = 1'b0;
    case (valid)
      2'b01:   grant_port = 1'b0;
      2'b10:   grant_port = 1'b1;
      2'b11:   grant_port = ~last_port;
      default: grant_port = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Two-port request arbiter and sequencer for the 32-bit registered ALU.
// Grants the ALU round-robin, issues the operation, captures the ALU's
// one-cycle registered result and returns it on a tagged response channel.
// Ports:
//   clk, reset_n                 - clock, synchronous active-low reset
//   reqN_valid/ready             - request handshake for requester N (0,1)
//   reqN_a/b/op/shift/tag        - operation payload and opaque tag
//   rsp_valid/ready              - response handshake (held until taken)
//   rsp_port/tag/data/err        - served requester, echoed tag, result, bad-op flag
//   busy                         - sequencer is not idle
//   alu_a/b/op/shift             - issue registers driving the ALU
//   alu_out                      - registered ALU result
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,

  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [OP_W-1:0]    req0_op,
  input  logic [SHIFT_W-1:0] req0_shift,
  input  logic [TAG_W-1:0]   req0_tag,

  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [OP_W-1:0]    req1_op,
  input  logic [SHIFT_W-1:0] req1_shift,
  input  logic [TAG_W-1:0]   req1_tag,

  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_port,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_err,

  output logic               busy,

  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OP_W-1:0]    alu_op,
  output logic [SHIFT_W-1:0] alu_shift,
  input  logic [DATA_W-1:0]  alu_out
);

  arb_state_e       state;
  logic             last_port;
  logic             win_any;
  logic             win_port;
  logic             accept;
  alu_req_t         sel_req;
  logic [TAG_W-1:0] sel_tag;

  rr_arb2 u_rr_arb2 (
    .valid      ({req1_valid, req0_valid}),
    .last_port  (last_port),
    .grant_any  (win_any),
    .grant_port (win_port)
  );

  // Only the winner sees ready, only in IDLE, and never while reset is held
  assign accept     = reset_n && (state == ST_IDLE) && win_any;
  assign req0_ready = accept && !win_port;
  assign req1_ready = accept &&  win_port;
  assign busy       = (state != ST_IDLE);

  // Payload of the winning requester
  always_comb begin
    sel_req = '0;
    sel_tag = '0;
    if (win_port) begin
      sel_req = '{a: req1_a, b: req1_b, op: req1_op, shift: req1_shift};
      sel_tag = req1_tag;
    end else begin
      sel_req = '{a: req0_a, b: req0_b, op: req0_op, shift: req0_shift};
      sel_tag = req0_tag;
    end
  end

  // Sequencer with registered issue and response outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      last_port <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_port  <= 1'b0;
      rsp_tag   <= '0;
      rsp_data  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_shift <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rsp_tag   <= sel_tag;
            rsp_port  <= win_port;
            last_port <= win_port;
            if (op_legal(sel_req.op)) begin
              alu_a     <= sel_req.a;
              alu_b     <= sel_req.b;
              alu_op    <= sel_req.op;
              alu_shift <= sel_req.shift;
              state     <= ST_EXEC;
            end else begin
              // Bad opcode: answer straight away, leave the ALU untouched
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              state     <= ST_DONE;
            end
          end
        end
        ST_EXEC: begin
          // ALU registers the issued operands at the end of this cycle
          state <= ST_CAPT;
        end
        ST_CAPT: begin
          rsp_data  <= alu_out;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Two-port request arbiter and sequencer for the 32-bit registered ALU. Accepts operation requests from two independent requesters over valid/ready handshakes and grants the single ALU round-robin. Each granted operation is issued, the ALU's one-cycle registered result is captured, and the result is returned on a shared tagged response channel. Sits between the instruction/issue logic and the ALU, which it drives directly.

## Interface
- TAG_W, 4, width of the requester-supplied tag echoed on the response
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- req0_valid / req1_valid  in  1  requester i presents an operation
- req0_ready / req1_ready  out  1  requester i's operation is accepted this cycle
- req0_a / req1_a  in  32  operand A
- req0_b / req1_b  in  32  operand B
- req0_op / req1_op  in  4  ALU opcode (0x0–0xA legal)
- req0_shift / req1_shift  in  5  shift amount
- req0_tag / req1_tag  in  TAG_W  opaque tag
- rsp_valid  out  1  response held until taken
- rsp_ready  in  1  consumer accepts response
- rsp_port  out  1  index of the requester served
- rsp_tag  out  TAG_W  echoed tag
- rsp_data  out  32  ALU result
- rsp_err  out  1  opcode was illegal; rsp_data = 0
- busy  out  1  state != IDLE
- alu_a, alu_b  out  32  to ALU operands
- alu_op  out  4  to ALU opcode
- alu_shift  out  5  to ALU shift amount
- alu_out  in  32  registered ALU result

## Operation
- States: IDLE, EXEC, CAPT, DONE.
- IDLE: winner = only valid port; if both valid, port != last_port. reqW_ready = 1 combinationally for winner only; loser's ready = 0. Both ready = 0 in all other states.
- On accept (valid & ready) with legal op: latch a/b/op/shift into issue registers driving alu_*, latch tag and port, last_port <= winner, -> EXEC.
- On accept with op > 0xA: no ALU issue (alu_* unchanged); rsp_valid <= 1, rsp_err <= 1, rsp_data <= 0, tag/port latched, last_port updated, -> DONE.
- EXEC: ALU samples alu_* at the edge ending this cycle; -> CAPT.
- CAPT: rsp_data <= alu_out, rsp_err <= 0, rsp_valid <= 1; -> DONE.
- DONE: hold all rsp_* stable while rsp_ready = 0; on rsp_ready = 1: rsp_valid <= 0, -> IDLE.
- Requests not accepted must be held by the requester; no queuing inside the block.
- Reset (reset_n = 0 at an edge), including mid-operation: state <= IDLE; in-flight op discarded, no response; last_port <= 1 (port 0 wins first tie); rsp_valid, rsp_err, rsp_port, rsp_tag, rsp_data, alu_a, alu_b, alu_op, alu_shift <= 0; busy = 0; both ready = 0 while reset_n = 0.

## Timing
- Accept at edge E0 -> alu_* valid during E0..E1 -> ALU registers at E1 -> rsp_valid high after E2 (2-cycle latency).
- Illegal op: rsp_valid high after E0 (0 extra cycles).
- Response taken at edge Ek -> earliest next accept at Ek+1; minimum 4 cycles per legal op with rsp_ready held high.
- alu_* hold last issued values between operations.
- ALU must be released from its own reset before the first issue; its reset is outside this block's control.

## Structure
- Shared package alu_pkg: 4-bit opcode constants OP_ADD = 0x0 through OP_XOR = 0xA, OP_MAX = 0xA, state enum encoding. The ALU and this block both use alu_pkg.
- One natural sub-module: rr_arb2 (2-way round-robin grant from valid pair and last_port, combinational).
- The ALU is instantiated at the parent level, not inside this block.

## Test plan
- Single op: port0 ADD a = 5, b = 7, tag = 3 -> ready0 one cycle; rsp_valid 2 cycles later, rsp_data = 12, rsp_port = 0, rsp_tag = 3, rsp_err = 0.
- Tie after reset: both valid (p0 SUB 10 − 3, p1 AND 0xF0 & 0x3C) -> p0 served first (data 7), then p1 (data 0x30); next tie grants p0 again.
- Backpressure: rsp_ready low 5 cycles -> rsp_* stable, both ready = 0, busy = 1; release -> IDLE next cycle.
- Illegal op 0xC on port1, tag 9 -> rsp_valid after the accept edge, rsp_err = 1, rsp_data = 0, rsp_tag = 9; alu_* unchanged.
- Shift: port0 op 0x4, a = 1, shift = 31 -> rsp_data = 0x80000000; op 0x5, a = 0x80000000, shift = 31 -> rsp_data = 1.
- Reset in CAPT: reset_n low one cycle -> no response ever; all outputs 0; next request completes normally.
